// File: rtl/enhanced_processor_pkg.sv
// Shared definitions for the enhanced bus-based processor:
// opcodes, step encodings and ALU function select.
package enhanced_processor_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_MVNZ = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_e;

    // Three-step ALU instructions versus single-step moves.
    function automatic logic is_alu(op_e op);
        return !(op inside {OP_MV, OP_MVI, OP_MVNZ});
    endfunction

    function automatic alu_e alu_sel(op_e op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/enhanced_processor_alu.sv
// Combinational ALU: add/sub with carry-borrow,
// plus bitwise and/or/xor (carry forced low).
module proc_alu
    import enhanced_processor_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  alu_e            func,
    output logic [BITS-1:0] result,
    output logic            carry
);

    // Result and carry for the selected function.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (func)
            ALU_ADD: {carry, result} = {1'b0, A} + {1'b0, B};
            ALU_SUB: begin
                result = A - B;
                carry  = (A < B);
            end
            ALU_AND: result = A & B;
            ALU_OR:  result = A | B;
            ALU_XOR: result = A ^ B;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/enhanced_processor.sv
// Multi-cycle bus processor: register file, bus mux,
// step counter, control decode and Z/C flags.
module enhanced_processor
    import enhanced_processor_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int NREGS = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [BITS-1:0] DIN,
    input  logic            Run,
    output logic            Done,
    output logic [BITS-1:0] Bus,
    output logic            Z,
    output logic            C
);

    localparam int RW  = $clog2(NREGS);
    localparam int IRW = 3 + 2 * RW;

    step_e           step_q, step_d;
    logic [IRW-1:0]  ir_q, ir_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] g_q, g_d;
    logic            z_q, z_d;
    logic            c_q, c_d;
    logic [BITS-1:0] regs_q [NREGS];

    op_e             op;
    logic [RW-1:0]   rx;
    logic [RW-1:0]   ry;
    logic [BITS-1:0] bus;
    logic [BITS-1:0] alu_res;
    logic            alu_c;
    logic            wr_en;
    logic            done;

    assign op = op_e'(ir_q[IRW-1 -: 3]);
    assign rx = ir_q[2*RW-1 -: RW];
    assign ry = ir_q[RW-1:0];

    // Bus source select; nothing drives it in T0.
    always_comb begin
        bus = '0;
        unique case (step_q)
            T0: bus = '0;
            T1: begin
                if (is_alu(op))
                    bus = regs_q[rx];
                else if (op == OP_MVI)
                    bus = DIN;
                else
                    bus = regs_q[ry];
            end
            T2: bus = regs_q[ry];
            T3: bus = g_q;
            default: bus = '0;
        endcase
    end

    proc_alu #(
        .BITS(BITS)
    ) u_alu (
        .A      (a_q),
        .B      (bus),
        .func   (alu_sel(op)),
        .result (alu_res),
        .carry  (alu_c)
    );

    // Step sequencing, datapath loads and register write enable.
    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        a_d    = a_q;
        g_d    = g_q;
        z_d    = z_q;
        c_d    = c_q;
        wr_en  = 1'b0;
        done   = 1'b0;
        unique case (step_q)
            T0: begin
                if (Run) begin
                    ir_d   = DIN[BITS-1 -: IRW];
                    step_d = T1;
                end
            end
            T1: begin
                if (is_alu(op)) begin
                    a_d    = bus;
                    step_d = T2;
                end else begin
                    wr_en  = !((op == OP_MVNZ) && z_q);
                    done   = 1'b1;
                    step_d = T0;
                end
            end
            T2: begin
                g_d    = alu_res;
                z_d    = (alu_res == '0);
                c_d    = alu_c;
                step_d = T3;
            end
            T3: begin
                wr_en  = 1'b1;
                done   = 1'b1;
                step_d = T0;
            end
            default: step_d = T0;
        endcase
    end

    // State update; reset wins over any pending write.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q <= T0;
            ir_q   <= '0;
            a_q    <= '0;
            g_q    <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            a_q    <= a_d;
            g_q    <= g_d;
            z_q    <= z_d;
            c_q    <= c_d;
            if (wr_en)
                regs_q[rx] <= bus;
        end
    end

    assign Done = done;
    assign Bus  = bus;
    assign Z    = z_q;
    assign C    = c_q;

endmodule
